// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared step encodings, redirect channel indices and defaults for the fetch PC generator.
package pc_gen_pkg;
  localparam int STEP_WIDTH = 2;
  localparam logic [31:0] START_PC_DEFAULT = 32'h0000_0000;
  localparam int REDIR_BRANCH = 0;
  localparam int REDIR_EXCP = 1;
  typedef enum logic [STEP_WIDTH-1:0] {
    STEP_PLUS_2 = 2'b00,
    STEP_PLUS_4 = 2'b01,
    STEP_PLUS_6 = 2'b10,
    STEP_PLUS_8 = 2'b11
  } step_code_e;
  function automatic logic [3:0] step_bytes(input logic [STEP_WIDTH-1:0] code);
    return {1'b0, code, 1'b0} + 4'd2;
  endfunction
endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: fixed-priority redirect arbiter; the lowest set channel index wins.
module pc_redirect_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REDIRECT = 2,
  parameter int IDX_W = 1
) (
  input  logic [NUM_REDIRECT-1:0]            redirect_valid,
  input  logic [NUM_REDIRECT*ADDR_WIDTH-1:0] redirect_pc,
  output logic                               win_valid,
  output logic [IDX_W-1:0]                   win_idx,
  output logic [ADDR_WIDTH-1:0]              win_pc
);
  // Scan from the lowest priority up so the last hit is the highest-priority channel.
  always_comb begin
    win_valid = |redirect_valid;
    win_idx = '0;
    win_pc = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (redirect_valid[i]) begin
        win_idx = IDX_W'(i);
        win_pc = redirect_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: registered fetch PC with prioritised redirects, stall-pending capture and length-based advance.
module pc_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REDIRECT = 2,
  parameter logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(pc_gen_pkg::START_PC_DEFAULT),
  parameter int STEP_WIDTH = pc_gen_pkg::STEP_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic                               fetch_ready,
  output logic                               pc_valid,
  output logic [ADDR_WIDTH-1:0]              pc_out,
  input  logic                               step_valid,
  input  logic [STEP_WIDTH-1:0]              step_code,
  input  logic [NUM_REDIRECT-1:0]            redirect_valid,
  input  logic [NUM_REDIRECT*ADDR_WIDTH-1:0] redirect_pc,
  output logic                               redirect_taken,
  output logic                               redirect_misalign
);
  import pc_gen_pkg::*;
  localparam int IDX_W = NUM_REDIRECT > 1 ? $clog2(NUM_REDIRECT) : 1;
  logic                  win_valid;
  logic [IDX_W-1:0]      win_idx;
  logic [ADDR_WIDTH-1:0] win_pc;
  logic                  pc_valid_q, taken_q, misalign_q;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pend_v_q, pend_v_d;
  logic [IDX_W-1:0]      pend_idx_q, pend_idx_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  advance, load, use_pend, capture, step_en;
  logic [ADDR_WIDTH-1:0] load_pc;

  pc_redirect_arb #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REDIRECT(NUM_REDIRECT),
    .IDX_W(IDX_W)
  ) u_arb (
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .win_valid(win_valid),
    .win_idx(win_idx),
    .win_pc(win_pc)
  );

  assign advance = pc_valid_q & ~stall;
  assign load = advance & (win_valid | pend_v_q);
  // A held redirect only beats a live one of strictly lower priority.
  assign use_pend = pend_v_q & (~win_valid | (pend_idx_q < win_idx));
  assign load_pc = use_pend ? pend_pc_q : win_pc;
  assign capture = stall & win_valid & (~pend_v_q | (win_idx <= pend_idx_q));
  assign step_en = advance & fetch_ready & step_valid;

  always_comb begin
    pc_d = load ? {load_pc[ADDR_WIDTH-1:1], 1'b0}
         : step_en ? pc_q + ADDR_WIDTH'(step_bytes(step_code)) : pc_q;
    pend_v_d = load ? 1'b0 : capture ? 1'b1 : pend_v_q;
    pend_idx_d = capture ? win_idx : pend_idx_q;
    pend_pc_d = capture ? win_pc : pend_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= START_PC;
      pc_valid_q <= 1'b0;
      taken_q <= 1'b0;
      misalign_q <= 1'b0;
      pend_v_q <= 1'b0;
      pend_idx_q <= '0;
      pend_pc_q <= '0;
    end else begin
      pc_q <= pc_d;
      pc_valid_q <= 1'b1;
      taken_q <= load;
      misalign_q <= load & load_pc[0];
      pend_v_q <= pend_v_d;
      pend_idx_q <= pend_idx_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign pc_out = pc_q;
  assign pc_valid = pc_valid_q;
  assign redirect_taken = taken_q;
  assign redirect_misalign = misalign_q;
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Registered next-PC generator for the front end; successor to the combinational next-PC select.
- Holds the architectural fetch PC and arbitrates NUM_REDIRECT prioritised redirect channels (branch, exception, …).
- Holds a pending redirect across stalls and advances by the decoded instruction length (2/4/6/8 bytes).
- Drives the instruction-fetch request address with a valid/ready handshake.

Parameters:
ADDR_WIDTH, 32, PC/address width in bits
NUM_REDIRECT, 2, number of redirect channels; index 0 = highest priority (0 = EX branch, 1 = Ctrl exception)
START_PC, 32'h0000_0000, PC loaded on reset
STEP_WIDTH, 2, width of step code (00:+2, 01:+4, 10:+6, 11:+8)

Ports:
clk  in  1  clock; only clock
rst  in  1  reset, synchronous, active-high
stall  in  1  pipeline stall; PC must not advance
fetch_ready  in  1  I-fetch accepts current PC
pc_valid  out  1  pc_out is a valid fetch request
pc_out  out  ADDR_WIDTH  current fetch PC (register output)
step_valid  in  1  decode supplies a length for the instruction at pc_out
step_code  in  STEP_WIDTH  length encoding, see STEP_WIDTH
redirect_valid  in  NUM_REDIRECT  per-channel redirect request
redirect_pc  in  NUM_REDIRECT*ADDR_WIDTH  channel i target at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
redirect_taken  out  1  one-cycle pulse: a redirect was loaded into pc_out this cycle edge
redirect_misalign  out  1  one-cycle pulse: the loaded redirect target had bit0 set

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - pc_out = START_PC, pc_valid = 0, redirect_taken = 0, redirect_misalign = 0.
  - Pending register cleared.
  - pc_valid rises on the first edge after rst deasserts.
- Reset mid-operation discards any pending redirect and any in-flight step.
- Arbitration:
  - Each cycle the fixed-priority winner = lowest set index of redirect_valid.
  - win_pc = that channel's target.
- Pending register (pend_v, pend_idx, pend_pc) captures a redirect that cannot be applied this cycle because stall = 1.
  - A new winner replaces the pending entry only if win_idx <= pend_idx; a lower-priority redirect is dropped.
- advance = pc_valid & ~stall.
- Next-state priority, evaluated each edge, highest first:
  1. rst.
  2. advance & (winner present | pend_v): load winner (beats pending unless pend_idx < win_idx), clear pend_v, pulse redirect_taken.
  3. stall & winner present: update pending per rule above; pc_out holds.
  4. advance & fetch_ready & step_valid: pc_out <= pc_out + {2,4,6,8}[step_code].
  5. Otherwise hold.
- A redirect while fetch_ready = 0 is still applied if not stalled; the outstanding fetch is abandoned.
- Redirect latency: redirect_valid at edge N (not stalled) → pc_out = target after edge N+1; 1 cycle.
- Stall release: a pending redirect applies on the first non-stalled edge.
- Misalignment:
  - A loaded target with bit0 = 1 is loaded with bit0 forced to 0.
  - redirect_misalign pulses in the same cycle as redirect_taken.
- Arithmetic: increment is modulo 2^ADDR_WIDTH; pc_out wraps from all-ones-minus-1 to 0 silently.
- pc_out never changes while stall = 1.
- step_valid = 0 with fetch_ready = 1 holds the PC (bubble); no default increment.

Decomposition:
- Shared define/package:
  - STEP_PLUS_2/4/6/8 codes
  - STEP_WIDTH
  - START_PC default
  - Redirect channel indices (REDIR_BRANCH = 0, REDIR_EXCP = 1)
- Sub-module pc_redirect_arb: parametrised fixed-priority arbiter returning win_valid, win_idx, win_pc. Combinational, instantiated once.
- Top module contains the pending register, PC register and step adder.

Test Plan:
- Reset then release with fetch_ready = 1, step_valid = 1, step_code = 01 for 3 cycles → pc_out 0x0, 0x4, 0x8, 0xC; pc_valid = 1 from first post-reset edge.
- Channels 0 (0x100) and 1 (0x200) valid in the same cycle, no stall → next pc_out = 0x100, redirect_taken = 1 for one cycle.
- stall = 1, channel 1 redirects 0x200, then channel 0 redirects 0x300 two cycles later, stall drops → pc_out stays fixed during stall, then 0x300. Reverse order (ch0 first, ch1 later) → 0x300 kept, 0x200 dropped.
- Redirect to 0x0000_0105 → pc_out = 0x104, redirect_misalign and redirect_taken pulse together.
- pc_out = 0xFFFF_FFFC, step_code = 11 → pc_out = 0x0000_0004. step_valid = 0 → pc_out unchanged.
- Pending redirect held under stall, rst asserted one cycle → pc_out = START_PC, pending lost; after release, no redirect_taken pulse.
